uart_block_sum_ctrl: RTL

- Sequencer for the UART receive → BRAM → accumulate → UART transmit datapath.
- Collects a block of N_WORDS received bytes into a single-port block RAM.
- Reads the block back with the RAM's fixed read latency and accumulates a modular sum.
- Offers the sum to the UART transmitter with a valid/ready handshake, then re-arms for the next block.
- Replaces ad-hoc address/counter logic in the top level with a clean FSM.

---
 rtl/uart_block_sum_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_block_sum_ctrl.sv
// Sequences UART rx bytes into a block RAM, reads the block back to form a modular sum, and offers that sum to uart_tx.
// Sum is offered N_WORDS+RD_LATENCY+1 cycles after the last write; it is held until the tx handshake, and bytes arriving meanwhile are dropped.
module uart_block_sum_ctrl #(
   parameter int N_DATA_BITS = 8,
   parameter int N_WORDS     = 16,
   parameter int ADDR_WIDTH  = $clog2(N_WORDS),
   parameter int RD_LATENCY  = 2,
   parameter int SUM_WIDTH   = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [N_DATA_BITS-1:0] i_rx_data,
   input  logic                   i_rx_data_valid,
   output logic                   o_mem_we,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic [N_DATA_BITS-1:0] o_mem_din,
   input  logic [N_DATA_BITS-1:0] i_mem_dout,
   output logic [N_DATA_BITS-1:0] o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_ready,
   output logic [SUM_WIDTH-1:0]   o_sum,
   output logic                   o_done,
   output logic                   o_overrun,
   output logic [1:0]             o_state
);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      READ = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_WORDS - 1);

   state_t                  state;
   logic                    rx_valid_q;
   logic                    byte_evt;
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic                    fill_done;
   logic                    rd_active;
   logic [RD_LATENCY:1]     vld_sr;
   logic [ADDR_WIDTH-1:0]   acc_cnt;
   logic [SUM_WIDTH-1:0]    acc;
   logic [SUM_WIDTH-1:0]    acc_next;

   // uart_rx may hold valid for several cycles, so only its rising edge counts as a byte
   assign byte_evt = i_rx_data_valid & ~rx_valid_q;
   assign acc_next = acc + SUM_WIDTH'(i_mem_dout);
   assign o_state  = state;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= FILL;
         rx_valid_q <= 1'b0;
         wr_ptr     <= '0;
         fill_done  <= 1'b0;
         rd_active  <= 1'b0;
         vld_sr     <= '0;
         acc_cnt    <= '0;
         acc        <= '0;
         o_mem_we   <= 1'b0;
         o_mem_addr <= '0;
         o_mem_din  <= '0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
         o_sum      <= '0;
         o_done     <= 1'b0;
         o_overrun  <= 1'b0;
      end else begin
         rx_valid_q <= i_rx_data_valid;
         o_mem_we   <= 1'b0;
         o_done     <= 1'b0;
         o_overrun  <= 1'b0;

         // vld_sr[k] marks that the address issued k cycles ago is now on i_mem_dout
         vld_sr[1] <= rd_active;
         for (int i = 2; i <= RD_LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
         if (vld_sr[RD_LATENCY]) begin
            acc     <= acc_next;
            acc_cnt <= acc_cnt + ADDR_WIDTH'(1);
         end

         case (state)
            FILL: begin
               if (fill_done) begin
                  // last write is on the bus this cycle; start reading next cycle
                  fill_done  <= 1'b0;
                  state      <= READ;
                  o_mem_addr <= '0;
                  rd_active  <= 1'b1;
                  acc_cnt    <= '0;
                  if (byte_evt) o_overrun <= 1'b1;
               end else if (byte_evt) begin
                  o_mem_we   <= 1'b1;
                  o_mem_addr <= wr_ptr;
                  o_mem_din  <= i_rx_data;
                  if (wr_ptr == LAST_ADDR) begin
                     wr_ptr    <= '0;
                     fill_done <= 1'b1;
                  end else begin
                     wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                  end
               end
            end
            READ: begin
               if (byte_evt) o_overrun <= 1'b1;
               if (rd_active) begin
                  if (o_mem_addr == LAST_ADDR) rd_active <= 1'b0;
                  else o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
               end
               if (vld_sr[RD_LATENCY] && acc_cnt == LAST_ADDR) begin
                  o_sum      <= acc_next;
                  o_tx_data  <= acc_next[N_DATA_BITS-1:0];
                  o_tx_valid <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (byte_evt) o_overrun <= 1'b1;
               if (o_tx_valid && i_tx_ready) begin
                  o_tx_valid <= 1'b0;
                  o_done     <= 1'b1;
                  acc        <= '0;
                  state      <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
